// File: rtl/muldiv_sequencer.sv
// Sequencer for the 8051 MUL AB / DIV AB datapath: four select iterations, then a PSW flag cycle.
// Optional divide-by-zero fast path: define MULDIV_DIV0_FAST_EN to skip the iterations when B is zero.
module muldiv_sequencer #(
    parameter int STATE_W = 8
) (
    input  logic               CPUClock,
    input  logic               RESET,
    input  logic               START_MUL,
    input  logic               START_DIV,
    input  logic               ABORT,
    input  logic               B_IS_ZERO,
    output logic [STATE_W-1:0] STATE,
    output logic               MUL_INST,
    output logic               DIV_INST,
    output logic               CY_ENABLE,
    output logic               CY_IN,
    output logic               OV_ENABLE,
    output logic               OV_IN,
    output logic               BUSY,
    output logic               DONE
);

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_ITER1 = 6'b000010,
        S_ITER2 = 6'b000100,
        S_ITER3 = 6'b001000,
        S_ITER4 = 6'b010000,
        S_FLAG  = 6'b100000
    } state_t;

    state_t state_q;
    logic   op_div_q;
    logic   div0_q;
    logic   start_s;
    logic   start_fast_s;
    logic   in_iter_s;
    logic   flag_s;

    assign start_s = START_MUL | START_DIV;

`ifdef MULDIV_DIV0_FAST_EN
    assign start_fast_s = ~START_MUL & START_DIV & B_IS_ZERO;
`else
    assign start_fast_s = 1'b0;
`endif

    // Phase sequencing, op-type latch and divide-by-zero capture.
    always_ff @(posedge CPUClock or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            op_div_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FLAG: begin
                    if (start_s) begin
                        // MUL wins when both requests arrive together
                        op_div_q <= ~START_MUL;
                        if (!START_MUL) begin
                            div0_q <= B_IS_ZERO;
                        end else begin
                            div0_q <= div0_q;
                        end
                        state_q <= start_fast_s ? S_FLAG : S_ITER1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ITER1: state_q <= ABORT ? S_IDLE : S_ITER2;
                S_ITER2: state_q <= ABORT ? S_IDLE : S_ITER3;
                S_ITER3: state_q <= ABORT ? S_IDLE : S_ITER4;
                S_ITER4: state_q <= S_FLAG;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_iter_s = |state_q[4:1];
    assign flag_s    = state_q[5];

    assign STATE     = STATE_W'(state_q);
    assign MUL_INST  = in_iter_s & ~op_div_q;
    assign DIV_INST  = in_iter_s & op_div_q;
    assign BUSY      = ~state_q[0];
    assign DONE      = flag_s;
    assign CY_ENABLE = flag_s;
    assign CY_IN     = 1'b0;
    assign OV_ENABLE = flag_s;
    // OV is a data value: for MUL it reflects the product high byte already written into B.
    assign OV_IN     = flag_s & (op_div_q ? div0_q : ~B_IS_ZERO);

endmodule
